// File: rtl/horn_pkg.sv
// horn_pkg: shared state encoding and default timing constants for the
// horn cadence controller.
package horn_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BEEP_ON    = 2'd1,
        BEEP_OFF   = 2'd2,
        CONTINUOUS = 2'd3
    } horn_state_t;

    // Defaults assume a 50 MHz clock: 10 ms debounce, 250 ms beeps and gaps.
    localparam int HORN_DEBOUNCE_CYCLES = 500_000;
    localparam int HORN_ON_CYCLES       = 12_500_000;
    localparam int HORN_OFF_CYCLES      = 12_500_000;
    localparam int HORN_BEEP_COUNT      = 3;

endpackage

// File: rtl/input_debounce.sv
// input_debounce: two-flop synchroniser followed by a counting debouncer.
// The debounced level only changes after the synchronised input has held
// the opposite value for CYCLES consecutive cycles; rise pulses for one
// cycle together with a 0->1 change of the debounced level.
module input_debounce #(
    parameter int CYCLES = 500_000
) (
    input  logic c50M,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int CW = $clog2(CYCLES);

    logic          syncA;
    logic          syncB;
    logic [CW-1:0] count;

    // Bring the asynchronous pushbutton into the c50M domain.
    always_ff @(posedge c50M or posedge reset) begin
        if (reset) begin
            syncA <= 1'b0;
            syncB <= 1'b0;
        end else begin
            syncA <= din;
            syncB <= syncA;
        end
    end

    // Count how long the input has disagreed with the debounced level; any
    // agreement restarts the count, so short bounces never reach the limit.
    always_ff @(posedge c50M or posedge reset) begin
        if (reset) begin
            count <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (syncB == dout) begin
                count <= '0;
            end else if (count == CW'(CYCLES - 1)) begin
                dout  <= syncB;
                rise  <= syncB;
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/horn_cadence.sv
// horn_cadence: turns a debounced pushbutton press into a fixed burst of
// timed beeps and a synchronised fault request into a continuous tone.
// HornEnable gates the downstream sawtooth generator.
module horn_cadence
    import horn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = HORN_DEBOUNCE_CYCLES,
    parameter int ON_CYCLES       = HORN_ON_CYCLES,
    parameter int OFF_CYCLES      = HORN_OFF_CYCLES,
    parameter int BEEP_COUNT      = HORN_BEEP_COUNT
) (
    input  logic c50M,
    input  logic reset,
    input  logic Button,
    input  logic Fault,
    output logic HornEnable,
    output logic Busy
);

    localparam int MAX_PHASE = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int PW        = $clog2(MAX_PHASE + 1);
    localparam int BW        = $clog2(BEEP_COUNT + 1);

    logic          buttonLevel;
    logic          buttonRise;
    logic          press;
    logic          faultMeta;
    logic          faultSync;
    horn_state_t   state;
    horn_state_t   nextState;
    logic [PW-1:0] phaseCnt;
    logic [BW-1:0] beepCnt;
    logic          hornNext;
    logic          busyNext;

    input_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) buttonDebounce (
        .c50M  (c50M),
        .reset (reset),
        .din   (Button),
        .dout  (buttonLevel),
        .rise  (buttonRise)
    );

    assign press = buttonRise & buttonLevel;

    // Fault is glitch-free, so a plain two-flop synchroniser is enough.
    always_ff @(posedge c50M or posedge reset) begin
        if (reset) begin
            faultMeta <= 1'b0;
            faultSync <= 1'b0;
        end else begin
            faultMeta <= Fault;
            faultSync <= faultMeta;
        end
    end

    // State register.
    always_ff @(posedge c50M or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; a fault overrides everything, including a press.
    always_comb begin
        nextState = state;
        if (faultSync) begin
            nextState = CONTINUOUS;
        end else begin
            unique case (state)
                IDLE: begin
                    if (press) begin
                        nextState = BEEP_ON;
                    end
                end
                BEEP_ON: begin
                    if (phaseCnt == '0) begin
                        nextState = (beepCnt == BW'(1)) ? IDLE : BEEP_OFF;
                    end
                end
                BEEP_OFF: begin
                    if (phaseCnt == '0) begin
                        nextState = BEEP_ON;
                    end
                end
                CONTINUOUS: begin
                    nextState = IDLE;
                end
                default: begin
                    nextState = IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs line up with the state.
    always_comb begin
        hornNext = (nextState == BEEP_ON) || (nextState == CONTINUOUS);
        busyNext = (nextState != IDLE);
    end

    // Registered outputs.
    always_ff @(posedge c50M or posedge reset) begin
        if (reset) begin
            HornEnable <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            HornEnable <= hornNext;
            Busy       <= busyNext;
        end
    end

    // Shared phase timer: reloaded on every state entry, counts down to zero and holds.
    always_ff @(posedge c50M or posedge reset) begin
        if (reset) begin
            phaseCnt <= '0;
        end else if (nextState != state) begin
            unique case (nextState)
                BEEP_ON:  phaseCnt <= PW'(ON_CYCLES - 1);
                BEEP_OFF: phaseCnt <= PW'(OFF_CYCLES - 1);
                default:  phaseCnt <= '0;
            endcase
        end else if (phaseCnt != '0) begin
            phaseCnt <= phaseCnt - PW'(1);
        end
    end

    // Beeps remaining in the burst; loaded on a fresh press, cleared whenever the burst ends or is aborted.
    always_ff @(posedge c50M or posedge reset) begin
        if (reset) begin
            beepCnt <= '0;
        end else if ((nextState == IDLE) || (nextState == CONTINUOUS)) begin
            beepCnt <= '0;
        end else if ((state == IDLE) && (nextState == BEEP_ON)) begin
            beepCnt <= BW'(BEEP_COUNT);
        end else if ((state == BEEP_ON) && (nextState == BEEP_OFF)) begin
            beepCnt <= beepCnt - BW'(1);
        end
    end

endmodule
